// File: rtl/led_tx_pkg.sv
// rtl/led_tx_pkg.sv - shared types and constants for the LED frame path
package led_tx_pkg;

    localparam int LED_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } tx_state_t;

endpackage

// File: rtl/div_tick.sv
// rtl/div_tick.sv - modulo-DIV counter with synchronous clear and last-count tick
module div_tick #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_frame_tx.sv
// rtl/led_frame_tx.sv - serial LED frame transmitter for a 595-class driver
module led_frame_tx
    import led_tx_pkg::*;
#(
    parameter int WIDTH     = LED_WIDTH,
    parameter int DIV       = 4,
    parameter bit SKIP_SAME = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] frame_in,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    tx_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [WIDTH-1:0] r_frame, w_frame_nxt;
    logic [WIDTH-1:0] r_last_frame, w_last_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [BW-1:0]    r_bit_cnt, w_bit_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_sdata, w_sdata_nxt;
    logic             r_latch, w_latch_nxt;
    logic             w_tick, w_accept, w_skip, w_div_clr;

    assign frame_ready = (r_state == IDLE);
    assign busy        = ~frame_ready;
    assign sclk        = r_sclk;
    assign sdata       = r_sdata;
    assign latch       = r_latch;

    assign w_accept  = frame_valid & frame_ready;
    assign w_skip    = SKIP_SAME && (frame_in == r_last_frame);
    assign w_shifted = r_shreg << 1;
    // Holding the divider clear while idle makes every frame start at count 0.
    assign w_div_clr = (r_state == IDLE);

    div_tick #(.DIV(DIV)) u_div_tick (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_div_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_frame      <= '0;
            r_last_frame <= '0;
            r_bit_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_latch      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_frame      <= w_frame_nxt;
            r_last_frame <= w_last_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_sclk       <= w_sclk_nxt;
            r_sdata      <= w_sdata_nxt;
            r_latch      <= w_latch_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_frame_nxt = r_frame;
        w_last_nxt  = r_last_frame;
        w_bit_nxt   = r_bit_cnt;
        w_sclk_nxt  = r_sclk;
        w_sdata_nxt = r_sdata;
        w_latch_nxt = r_latch;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_skip) begin
                    w_shreg_nxt = frame_in;
                    w_frame_nxt = frame_in;
                    w_bit_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                    w_sdata_nxt = frame_in[WIDTH-1];
                    w_state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_tick) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_latch_nxt = 1'b1;
                        w_state_nxt = LATCH;
                    end else begin
                        w_shreg_nxt = w_shifted;
                        w_sdata_nxt = w_shifted[WIDTH-1];
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_state_nxt = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (w_tick) begin
                    w_latch_nxt = 1'b0;
                    w_last_nxt  = r_frame;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
